// File: rtl/lstm_pkg.sv
// Shared state encoding and fixed-point constant helpers for the sequenced LSTM gates.
package lstm_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_ACT  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    MAC  = ST_MAC,
    ACT  = ST_ACT,
    DONE = ST_DONE
  } state_t;

  // Constants are returned 64 bits wide; callers cast to their own word width.
  function automatic logic [63:0] fx_one(input int frac);
    return 64'd1 << frac;
  endfunction

  function automatic logic [63:0] fx_half(input int frac);
    return 64'd1 << (frac - 1);
  endfunction

  function automatic logic [63:0] fx_knot_hi(input int frac);
    return 64'd5 << (frac - 1);
  endfunction

  function automatic logic [63:0] fx_offs(input int frac);
    return 64'd3 << (frac - 3);
  endfunction

endpackage

// File: rtl/tanh_pwl.sv
// Combinational piecewise-linear tanh on a signed fixed-point word (FRAC >= 3).
module tanh_pwl
  import lstm_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24
) (
  input  logic signed [WIDTH-1:0] z_i,
  output logic signed [WIDTH-1:0] a_o
);

  localparam logic [WIDTH:0] ONE     = (WIDTH+1)'(fx_one(FRAC));
  localparam logic [WIDTH:0] HALF    = (WIDTH+1)'(fx_half(FRAC));
  localparam logic [WIDTH:0] KNOT_HI = (WIDTH+1)'(fx_knot_hi(FRAC));
  localparam logic [WIDTH:0] OFFS    = (WIDTH+1)'(fx_offs(FRAC));

  logic [WIDTH:0] mag;
  logic [WIDTH:0] r;

  // One extra bit so the most-negative input has a representable magnitude.
  always_comb begin
    mag = z_i[WIDTH-1] ? (~{1'b1, z_i} + (WIDTH+1)'(1)) : {1'b0, z_i};
    if (mag < HALF) begin
      r = mag;
    end else if (mag < KNOT_HI) begin
      r = (mag >> 2) + OFFS;
    end else begin
      r = ONE;
    end
    a_o = z_i[WIDTH-1] ? WIDTH'(~r + (WIDTH+1)'(1)) : WIDTH'(r);
  end

endmodule

// File: rtl/act_tanh_seq.sv
// Sequenced tanh neuron: one shared multiplier, NUM MAC cycles, then PWL tanh.
// Optional ACT_TANH_SEQ_PREACT_EN adds o_z/o_sat pre-activation taps for backprop.
module act_tanh_seq
  import lstm_pkg::*;
#(
  parameter int NUM   = 2,
  parameter int WIDTH = 32,
  parameter int FRAC  = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  output logic                 o_busy,
  input  logic [NUM*WIDTH-1:0] i_x,
  input  logic                 wr,
  input  logic [NUM*WIDTH-1:0] i_w,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_wr_err,
  output logic [WIDTH-1:0]     o_a,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [NUM*WIDTH-1:0] o_w,
  output logic [WIDTH-1:0]     o_b
`ifdef ACT_TANH_SEQ_PREACT_EN
  ,
  output logic [WIDTH-1:0]     o_z,
  output logic                 o_sat
`endif
);

  localparam int IDXW = (NUM > 1) ? $clog2(NUM) : 1;

  state_t                    state_q;
  logic [NUM*WIDTH-1:0]      w_q, wl_q, x_q;
  logic [WIDTH-1:0]          b_q, a_q;
  logic signed [2*WIDTH-1:0] acc_q;
  logic [IDXW-1:0]           idx_q;
  logic                      valid_q, wr_err_q;

  logic signed [WIDTH-1:0]   x_cur, w_cur, z_sat, a_pwl;
  logic signed [2*WIDTH-1:0] prod, bias_ext, z_full;
  logic [WIDTH:0]            z_hi;
  logic                      z_clip;

  assign x_cur    = x_q[idx_q*WIDTH +: WIDTH];
  assign w_cur    = wl_q[idx_q*WIDTH +: WIDTH];
  assign prod     = x_cur * w_cur;
  assign bias_ext = {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign z_full   = acc_q >>> FRAC;

  // z fits in WIDTH bits only when the top WIDTH+1 bits are a pure sign extension.
  assign z_hi   = z_full[2*WIDTH-1:WIDTH-1];
  assign z_clip = !((&z_hi) || (~|z_hi));
  assign z_sat  = !z_clip         ? z_full[WIDTH-1:0] :
                  z_full[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                      {1'b0, {(WIDTH-1){1'b1}}};

  tanh_pwl #(.WIDTH(WIDTH), .FRAC(FRAC)) u_tanh (
    .z_i(z_sat),
    .a_o(a_pwl)
  );

`ifdef ACT_TANH_SEQ_PREACT_EN
  logic [WIDTH-1:0] z_q;
  logic             sat_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      z_q   <= '0;
      sat_q <= 1'b0;
    end else if (state_q == ACT) begin
      z_q   <= z_sat;
      sat_q <= z_clip;
    end else if (state_q == DONE && i_ready) begin
      sat_q <= 1'b0;
    end
  end

  assign o_z   = z_q;
  assign o_sat = sat_q & valid_q;
`endif

  // Weights are snapshotted at start so a same-cycle write cannot leak into the run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      w_q      <= '0;
      wl_q     <= '0;
      x_q      <= '0;
      b_q      <= '0;
      a_q      <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr && (state_q != IDLE);
      if (wr && state_q == IDLE) begin
        w_q <= i_w;
        b_q <= i_b;
      end
      case (state_q)
        IDLE: begin
          if (i_start) begin
            x_q     <= i_x;
            wl_q    <= w_q;
            acc_q   <= bias_ext <<< FRAC;
            idx_q   <= '0;
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_q + prod;
          if (idx_q == IDXW'(NUM - 1)) begin
            state_q <= ACT;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        ACT: begin
          a_q     <= a_pwl;
          valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          if (valid_q && i_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy   = (state_q != IDLE);
  assign o_valid  = valid_q;
  assign o_a      = a_q;
  assign o_wr_err = wr_err_q;
  assign o_w      = w_q;
  assign o_b      = b_q;

endmodule

// File: tb/tb_act_tanh_seq.sv
// Directed bench for act_tanh_seq (NUM=2, WIDTH=32, FRAC=24); also checks o_z/o_sat
// when built with ACT_TANH_SEQ_PREACT_EN.
module tb_act_tanh_seq;

  localparam logic [31:0] ONE  = 32'h0100_0000;
  localparam logic [31:0] HALF = 32'h0080_0000;
  localparam logic [31:0] QTR  = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_start = 1'b0;
  logic        o_busy;
  logic [63:0] i_x = '0;
  logic        wr = 1'b0;
  logic [63:0] i_w = '0;
  logic [31:0] i_b = '0;
  logic        o_wr_err;
  logic [31:0] o_a;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [63:0] o_w;
  logic [31:0] o_b;
`ifdef ACT_TANH_SEQ_PREACT_EN
  logic [31:0] o_z;
  logic        o_sat;
`endif

  int checks = 0;
  int failures = 0;

  act_tanh_seq #(.NUM(2), .WIDTH(32), .FRAC(24)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .o_busy(o_busy), .i_x(i_x),
    .wr(wr), .i_w(i_w), .i_b(i_b), .o_wr_err(o_wr_err), .o_a(o_a),
    .o_valid(o_valid), .i_ready(i_ready), .o_w(o_w), .o_b(o_b)
`ifdef ACT_TANH_SEQ_PREACT_EN
    , .o_z(o_z), .o_sat(o_sat)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_wb(input logic [31:0] w1, input logic [31:0] w0, input logic [31:0] b);
    @(negedge clk);
    wr = 1'b1; i_w = {w1, w0}; i_b = b;
    @(negedge clk);
    wr = 1'b0;
  endtask

  // Pulse start, then count edges (sampling edge = 1) until o_valid, bounded.
  task automatic start_wait(input logic [31:0] x1, input logic [31:0] x0, output int n);
    @(negedge clk);
    i_x = {x1, x0}; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0; n = 1;
    while (!o_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run(input string tag, input logic [31:0] x1, input logic [31:0] x0,
                     input logic [31:0] exp_a, input logic [31:0] exp_z, input logic exp_sat);
    int n;
    start_wait(x1, x0, n);
    check({tag, "_lat"}, 64'(n), 64'd4);
    check({tag, "_a"}, 64'(o_a), 64'(exp_a));
`ifdef ACT_TANH_SEQ_PREACT_EN
    check({tag, "_z"}, 64'(o_z), 64'(exp_z));
    check({tag, "_sat"}, 64'(o_sat), 64'(exp_sat));
`else
    if (exp_sat === 1'bx) check({tag, "_zsat"}, 64'(exp_z), 64'd0);
`endif
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    check({tag, "_idle"}, {62'd0, o_busy, o_valid}, 64'd0);
  endtask

  initial begin : main
    int n;
    logic [31:0] a_hold;

    #2;
    check("rst_out", {o_busy, o_valid, o_wr_err, o_a, o_b}, 64'd0);
    check("rst_w", o_w, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // z = 0.25*0.5 + 0.5*0.5 = 0.375 (linear segment)
    write_wb(HALF, HALF, 32'd0);
    check("wr_w", o_w, {HALF, HALF});
    run("t1", HALF, QTR, 32'h0060_0000, 32'h0060_0000, 1'b0);

    // z = +/-2.0 -> +/-0.875
    write_wb(ONE, ONE, 32'd0);
    run("t2p", ONE, ONE, 32'h00E0_0000, 32'h0200_0000, 1'b0);
    run("t2n", 32'hFF00_0000, 32'hFF00_0000, 32'hFF20_0000, 32'hFE00_0000, 1'b0);

    // bias 1.0: z = 5.0 -> 1.0; z = -127 -> -1.0; z = -255 clipped to -128 -> -1.0
    write_wb(ONE, ONE, ONE);
    run("t3p", 32'h0200_0000, 32'h0200_0000, ONE, 32'h0500_0000, 1'b0);
    run("t3n", 32'hC000_0000, 32'hC000_0000, 32'hFF00_0000, 32'h8100_0000, 1'b0);
    run("t3s", 32'h8000_0000, 32'h8000_0000, 32'hFF00_0000, 32'h8000_0000, 1'b1);

    // Hold in DONE with i_ready low; start pulses must be ignored.
    start_wait(HALF, HALF, n);
    check("t4_lat", 64'(n), 64'd4);
    a_hold = o_a;
    check("t4_a", 64'(a_hold), 64'h00E0_0000);
    for (int i = 0; i < 5; i++) begin
      i_start = (i % 2 == 0);
      @(negedge clk);
      check("t4_hold", {31'd0, o_busy, o_valid, o_a}, {31'd0, 1'b1, 1'b1, a_hold});
    end
    i_start = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    check("t4_ret", {62'd0, o_busy, o_valid}, 64'd0);
    @(negedge clk);
    check("t4_noq", 64'(o_busy), 64'd0);

    // Write during MAC is dropped with a one-cycle error pulse.
    write_wb(QTR, QTR, 32'd0);
    @(negedge clk);
    i_x = {ONE, ONE}; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wr = 1'b1; i_w = {ONE, ONE}; i_b = ONE;
    @(negedge clk);
    wr = 1'b0;
    check("t5_err", 64'(o_wr_err), 64'd1);
    check("t5_w", o_w, {QTR, QTR});
    @(negedge clk);
    check("t5_err_end", 64'(o_wr_err), 64'd0);
    n = 0;
    while (!o_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5_a", 64'(o_a), 64'(HALF));
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;

    // Write together with start: run uses old weights, o_w/o_b show new ones next cycle.
    @(negedge clk);
    wr = 1'b1; i_w = {ONE, ONE}; i_b = ONE;
    i_x = {ONE, ONE}; i_start = 1'b1;
    @(negedge clk);
    wr = 1'b0; i_start = 1'b0;
    check("t5b_w", o_w, {ONE, ONE});
    check("t5b_b", 64'(o_b), 64'(ONE));
    check("t5b_err", 64'(o_wr_err), 64'd0);
    n = 1;
    while (!o_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5b_lat", 64'(n), 64'd4);
    check("t5b_a", 64'(o_a), 64'(HALF));
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    run("t5c", ONE, ONE, ONE, 32'h0300_0000, 1'b0);

    // Reset in MAC clears everything immediately.
    @(negedge clk);
    i_x = {ONE, ONE}; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("t6_mac", 64'(o_busy), 64'd1);
    rst = 1'b0;
    #1;
    check("t6_rst", {o_busy, o_valid, o_b}, 64'd0);
    check("t6_rst_w", o_w, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Reset while o_valid is high drops it without a clock edge.
    start_wait(ONE, ONE, n);
    check("t6_zero_a", {63'd0, o_valid} | {32'd0, o_a}, 64'd1);
    rst = 1'b0;
    #1;
    check("t6_vdrop", {62'd0, o_busy, o_valid}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run("t6z", ONE, ONE, 32'd0, 32'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
